// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter that shares one start/done compute unit between N requesters.
// Forwards the winner's operands, pulses start, waits for done or timeout, and acks.
module shared_unit_arbiter #(
   parameter int N       = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   op_a_in,
   input  logic [N*WIDTH-1:0]   op_b_in,
   input  logic                 unit_done,
   input  logic [2*WIDTH-1:0]   unit_result,
   output logic                 unit_start,
   output logic [WIDTH-1:0]     unit_a,
   output logic [WIDTH-1:0]     unit_b,
   output logic [N-1:0]         grant,
   output logic [N-1:0]         ack,
   output logic [2*WIDTH-1:0]   result,
   output logic                 error,
   output logic                 busy
);

   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int IW1 = IW + 1;
   localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
   localparam logic [N-1:0]  ONE  = N'(1);

   // Handshake: unit_start is a one-cycle pulse with unit_a/unit_b stable from then on;
   // unit_done is honoured only in WAIT, and unit_result is taken in that same cycle.
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   sel;
   logic [TW-1:0]   timer;
   logic [WIDTH-1:0] a_arr [N];
   logic [WIDTH-1:0] b_arr [N];
   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic [IW1-1:0]  pick_s;

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign a_arr[i] = op_a_in[i*WIDTH +: WIDTH];
      assign b_arr[i] = op_b_in[i*WIDTH +: WIDTH];
   end

   // First set request scanning ptr, ptr+1, ... with wrap at N.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_s     = '0;
      for (int k = 0; k < N; k++) begin
         pick_s = {1'b0, ptr} + IW1'(k);
         if (pick_s >= IW1'(N)) pick_s = pick_s - IW1'(N);
         if (!pick_found && req[pick_s[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = pick_s[IW-1:0];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         sel        <= '0;
         timer      <= '0;
         unit_start <= 1'b0;
         unit_a     <= '0;
         unit_b     <= '0;
         grant      <= '0;
         ack        <= '0;
         result     <= '0;
         error      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  sel        <= pick_idx;
                  unit_a     <= a_arr[pick_idx];
                  unit_b     <= b_arr[pick_idx];
                  grant      <= ONE << pick_idx;
                  unit_start <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               unit_start <= 1'b0;
               timer      <= '0;
               error      <= 1'b0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               // Done wins over a coinciding timeout; the timer stops at TMAX.
               if (unit_done) begin
                  result <= unit_result;
                  ack    <= grant;
                  state  <= S_RESPOND;
               end else if (timer == TMAX) begin
                  result <= '0;
                  error  <= 1'b1;
                  ack    <= grant;
                  state  <= S_RESPOND;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_RESPOND: begin
               ack   <= '0;
               grant <= '0;
               busy  <= 1'b0;
               ptr   <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Directed bench for shared_unit_arbiter (N=4, WIDTH=8, TIMEOUT=15) with a hand-driven
// model of the shared unit and hand-computed expected values.
module tb_shared_unit_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] op_a_in = '0;
   logic [31:0] op_b_in = '0;
   logic        unit_done = 1'b0;
   logic [15:0] unit_result = '0;
   logic        unit_start;
   logic [7:0]  unit_a, unit_b;
   logic [3:0]  grant, ack;
   logic [15:0] result;
   logic        error, busy;

   int n_checks = 0;
   int n_errors = 0;

   shared_unit_arbiter #(.N(4), .WIDTH(8), .TIMEOUT(15)) dut (
      .clock(clock), .reset(reset), .req(req), .op_a_in(op_a_in), .op_b_in(op_b_in),
      .unit_done(unit_done), .unit_result(unit_result), .unit_start(unit_start),
      .unit_a(unit_a), .unit_b(unit_b), .grant(grant), .ack(ack), .result(result),
      .error(error), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"},  32'(unit_start), 0);
      check({tag, "_a"},      32'(unit_a), 0);
      check({tag, "_b"},      32'(unit_b), 0);
      check({tag, "_grant"},  32'(grant), 0);
      check({tag, "_ack"},    32'(ack), 0);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_error"},  32'(error), 0);
      check({tag, "_busy"},   32'(busy), 0);
   endtask

   // One full transaction from IDLE. d = WAIT edge on which done is sampled, 0 = never.
   task automatic txn(input string tag, input logic [3:0] g, input logic [7:0] a,
                      input logic [7:0] b, input int d, input logic [15:0] res,
                      input logic err_exp, input bit drop);
      int n;
      logic [31:0] sa, sb;
      n = 0;
      do begin tick(); n++; end while (grant == 4'd0 && n < 8);
      check({tag, "_grant_wait"}, 32'(n), 1);
      check({tag, "_grant"}, 32'(grant), 32'(g));
      check({tag, "_start_hi"}, 32'(unit_start), 1);
      check({tag, "_unit_a"}, 32'(unit_a), 32'(a));
      check({tag, "_unit_b"}, 32'(unit_b), 32'(b));
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_ack_idle"}, 32'(ack), 0);
      unit_done = 1'b0;
      sa = op_a_in; sb = op_b_in;
      op_a_in = ~sa; op_b_in = ~sb;
      tick();
      check({tag, "_start_lo"}, 32'(unit_start), 0);
      check({tag, "_a_held"}, 32'(unit_a), 32'(a));
      check({tag, "_b_held"}, 32'(unit_b), 32'(b));
      check({tag, "_err_clr"}, 32'(error), 0);
      op_a_in = sa; op_b_in = sb;
      if (drop) req = '0;
      if (d > 0) begin
         repeat (d - 1) begin
            tick();
            check({tag, "_no_early_ack"}, 32'(ack), 0);
         end
         unit_done = 1'b1;
         unit_result = res;
         tick();
         unit_done = 1'b0;
         unit_result = 16'hdead;
      end else begin
         n = 0;
         do begin tick(); n++; end while (ack == 4'd0 && n < 40);
         check({tag, "_wait_cycles"}, 32'(n), 16);
      end
      check({tag, "_ack"}, 32'(ack), 32'(g));
      check({tag, "_result"}, 32'(result), 32'(res));
      check({tag, "_error"}, 32'(error), 32'(err_exp));
      tick();
      check({tag, "_ack_off"}, 32'(ack), 0);
      check({tag, "_grant_off"}, 32'(grant), 0);
      check({tag, "_busy_off"}, 32'(busy), 0);
   endtask

   initial begin
      op_a_in = {8'd35, 8'd23, 8'd7, 8'd11};
      op_b_in = {8'd5, 8'd3, 8'd6, 8'd2};
      tick(); tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 0);

      // Fairness with all requests held and a 1-cycle unit
      req = 4'b1111;
      txn("fair0", 4'b0001, 8'd11, 8'd2, 1, 16'd22, 1'b0, 1'b0);
      txn("fair1", 4'b0010, 8'd7, 8'd6, 1, 16'd42, 1'b0, 1'b0);
      txn("fair2", 4'b0100, 8'd23, 8'd3, 1, 16'd69, 1'b0, 1'b0);
      txn("fair3", 4'b1000, 8'd35, 8'd5, 1, 16'd175, 1'b0, 1'b0);
      txn("fair4", 4'b0001, 8'd11, 8'd2, 1, 16'd22, 1'b0, 1'b1);

      // Single request, done three cycles after start
      req = 4'b0010;
      txn("single", 4'b0010, 8'd7, 8'd6, 3, 16'd42, 1'b0, 1'b1);

      // Request dropped one cycle after grant still completes
      req = 4'b0100;
      txn("dropped", 4'b0100, 8'd23, 8'd3, 2, 16'd69, 1'b0, 1'b1);

      // Pointer now at 3: 0101 serves 0 before 2
      req = 4'b0101;
      txn("ptr0", 4'b0001, 8'd11, 8'd2, 1, 16'd22, 1'b0, 1'b0);
      txn("ptr1", 4'b0100, 8'd23, 8'd3, 1, 16'd69, 1'b0, 1'b1);

      // Timeout, then a normal transaction clears error
      req = 4'b1000;
      txn("timeout", 4'b1000, 8'd35, 8'd5, 0, 16'd0, 1'b1, 1'b1);
      req = 4'b0001;
      txn("after_to", 4'b0001, 8'd11, 8'd2, 2, 16'd22, 1'b0, 1'b1);

      // Reset during WAIT with req held; pointer at 1
      req = 4'b1001;
      tick();
      check("rst_pre_grant", 32'(grant), 32'(4'b1000));
      tick();
      check("rst_pre_wait", 32'(unit_start), 0);
      tick();
      reset = 1'b1;
      #1;
      check_all_zero("rst_async");
      tick(); tick();
      check_all_zero("rst_held");
      reset = 1'b0;
      unit_done = 1'b1;
      unit_result = 16'd99;
      txn("post_rst", 4'b0001, 8'd11, 8'd2, 2, 16'd22, 1'b0, 1'b0);
      txn("post_rst2", 4'b1000, 8'd35, 8'd5, 1, 16'd175, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shared_unit_arbiter.md
# shared_unit_arbiter

Round-robin arbiter and sequencer that shares one start/done-handshaked compute unit (e.g. the sequential multiplier) between N requesters. It selects a requester, forwards that requester's operands, issues a one-cycle start, and waits for done or a timeout. It then returns the result with a one-cycle acknowledge to the served requester. It sits between the requester-side interface units and the shared unit.

## Interface
- N, default 4: number of requesters (2..8).
- WIDTH, default 8: operand width; result is 2*WIDTH.
- TIMEOUT, default 255: maximum WAIT cycles before abort (1..2^16-1).

- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  request level, one bit per requester.
- op_a_in  in  N*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH].
- op_b_in  in  N*WIDTH  operand B; same packing.
- unit_done  in  1  done from shared unit.
- unit_result  in  2*WIDTH  result from shared unit; valid while unit_done=1.
- unit_start  out  1  start pulse to shared unit.
- unit_a  out  WIDTH  latched operand A to unit.
- unit_b  out  WIDTH  latched operand B to unit.
- grant  out  N  one-hot; the requester currently being served.
- ack  out  N  one-hot, one-cycle completion pulse.
- result  out  2*WIDTH  latched result; valid while ack≠0, held until next latch.
- error  out  1  timeout flag; valid while ack≠0, held until next ISSUE.
- busy  out  1  high in every state except IDLE.

## Operation
- All outputs are registered or decoded from state. Reset forces state IDLE and round-robin pointer ptr=0. It drives every output and internal register to 0, regardless of state.
- IDLE:
  - If req≠0, pick the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Latch that requester's operands into unit_a/unit_b and set its grant bit.
  - Go to ISSUE.
- ISSUE:
  - unit_start=1 for exactly this one cycle.
  - Clear the timer and error.
  - Go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - If unit_done=1, latch unit_result into result and go to RESPOND. Done takes priority if done and timeout coincide.
  - Else if timer==TIMEOUT, set error=1, result=0, and go to RESPOND.
- RESPOND:
  - ack=grant for exactly one cycle.
  - ptr←(served index+1) mod N.
  - Go to IDLE; grant clears on leaving.
- req is sampled only in IDLE. Dropping req mid-service does not cancel the transaction, and ack is still issued. A requester holding req after ack is re-served only when round-robin order reaches it again.
- unit_done is ignored in IDLE, ISSUE and RESPOND.
- Operand inputs may change after grant without affecting unit_a/unit_b.
- timer width is ceil(log2(TIMEOUT+1)); it never wraps.

## Timing
- Edge 0 samples req≠0 in IDLE. After edge 0: grant, unit_a/unit_b valid, unit_start=1, busy=1.
- After edge 1: unit_start=0 (state WAIT).
- Edge m samples unit_done=1. After edge m: ack, result valid.
- After edge m+1: ack=0, grant=0, busy=0 (IDLE). The earliest next grant follows edge m+2.
- Minimum req-to-ack latency is 3 cycles, when done is sampled at the first WAIT edge. Timeout ack follows edge 1+TIMEOUT+1.
- Reset may assert in any state, including mid-WAIT. Outputs go to 0 immediately, with no ack for the aborted transaction. A unit_done arriving after reset release is ignored.

## Test plan
- Single request: N=4, WIDTH=8; req=0010, a=7, b=6; the model unit raises done 3 cycles after start with 42. Required:
  - unit_start high for exactly 1 cycle, with unit_a=7 and unit_b=6.
  - grant=0010.
  - ack=0010 for 1 cycle, with result=42 and error=0.
- Fairness: req=1111 held continuously; unit done after 1 cycle. Required: grant sequence 0001, 0010, 0100, 1000, 0001, one IDLE cycle between transactions.
- Pointer: after serving requester 2, apply req=0101. Required: grant=0001 (scan starts at 3), then 0100.
- Timeout: TIMEOUT=15; unit never raises done. Required: ack after 16 WAIT cycles with error=1 and result=0. On the next transaction, error clears at ISSUE.
- Reset and spurious done: assert reset during WAIT; req=1001 held through reset. Required:
  - All outputs are 0 during reset.
  - After release, grant=0001 first.
  - A unit_done pulse injected in IDLE produces no ack.
- Dropped request: req=0100 rises and falls one cycle after grant. Required: the transaction completes and ack=0100 is still issued.
